// File: rtl/rgb_pkg.sv
// rgb_pkg: hue phase encoding and default timing constants for the RGB hue sequencer.
package rgb_pkg;
    typedef enum logic [2:0] {
        PH_RG_UP,
        PH_R_DN,
        PH_GB_UP,
        PH_G_DN,
        PH_BR_UP,
        PH_B_DN
    } phase_e;
    localparam int DEF_PWM_INTERVAL = 1200;
    localparam int DEF_STEP_PERIODS = 1;
endpackage

// File: rtl/strobe_divider.sv
// strobe_divider: emits a one-cycle tick on every N-th accepted strobe.
module strobe_divider #(
    parameter int N = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = N > 1 ? $clog2(N) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic last;
    always_comb begin
        last  = cnt_q == CW'(N - 1);
        cnt_d = last ? '0 : cnt_q + 1'b1;
        tick  = en && last;
    end
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt_q <= '0;
        else if (en)
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/rgb_hue_sequencer.sv
// rgb_hue_sequencer: steps an RGB duty triple around a six-phase hue wheel,
// one ramp step per STEP_PERIODS accepted PWM period strobes.
module rgb_hue_sequencer
    import rgb_pkg::*;
#(
    parameter int PWM_INTERVAL = DEF_PWM_INTERVAL,
    parameter int STEP_PERIODS = DEF_STEP_PERIODS,
    parameter int DW           = $clog2(PWM_INTERVAL + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          restart,
    input  logic          period_done,
    output logic [DW-1:0] duty_r,
    output logic [DW-1:0] duty_g,
    output logic [DW-1:0] duty_b,
    output logic          duty_update,
    output logic [2:0]    phase,
    output logic          wrap
);
    localparam logic [DW-1:0] F = DW'(PWM_INTERVAL);
    logic [DW-1:0] k_q, k_d, r_q, g_q, b_q, r_n, g_n, b_n, fk;
    phase_e        ph_q, ph_d;
    logic          upd_q, upd_d, wrap_q, wrap_d, step, last_k;

    strobe_divider #(.N(STEP_PERIODS)) u_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (restart),
        .en   (enable && period_done && !restart),
        .tick (step)
    );

    always_comb begin
        last_k = k_q == F - 1'b1;
        k_d    = k_q;
        ph_d   = ph_q;
        upd_d  = 1'b0;
        wrap_d = 1'b0;
        if (restart) begin
            k_d   = '0;
            ph_d  = PH_RG_UP;
            upd_d = 1'b1;
        end else if (step) begin
            k_d    = last_k ? '0 : k_q + 1'b1;
            ph_d   = !last_k ? ph_q : ph_q == PH_B_DN ? PH_RG_UP : phase_e'(ph_q + 3'd1);
            upd_d  = 1'b1;
            wrap_d = last_k && ph_q == PH_B_DN;
        end
    end

    // k never exceeds F-1, so F-k stays within 1..F
    always_comb begin
        fk  = F - k_d;
        r_n = F;
        g_n = k_d;
        b_n = '0;
        case (ph_d)
            PH_R_DN:  begin r_n = fk; g_n = F;  b_n = '0;  end
            PH_GB_UP: begin r_n = '0; g_n = F;  b_n = k_d; end
            PH_G_DN:  begin r_n = '0; g_n = fk; b_n = F;   end
            PH_BR_UP: begin r_n = k_d; g_n = '0; b_n = F;  end
            PH_B_DN:  begin r_n = F;  g_n = '0; b_n = fk;  end
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q    <= '0;
            ph_q   <= PH_RG_UP;
            r_q    <= F;
            g_q    <= '0;
            b_q    <= '0;
            upd_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            k_q    <= k_d;
            ph_q   <= ph_d;
            upd_q  <= upd_d;
            wrap_q <= wrap_d;
            if (upd_d) begin
                r_q <= r_n;
                g_q <= g_n;
                b_q <= b_n;
            end
        end
    end

    assign duty_r      = r_q;
    assign duty_g      = g_q;
    assign duty_b      = b_q;
    assign duty_update = upd_q;
    assign phase       = ph_q;
    assign wrap        = wrap_q;
endmodule

// File: doc/rgb_hue_sequencer.md
RGB_HUE_SEQUENCER -- requirements
Module: rgb_hue_sequencer

Interface
REQ-001 Parameters SHALL be:
- PWM_INTERVAL, default 1200: PWM period in clk cycles; also full-scale duty.
- STEP_PERIODS, default 1: number of PWM periods per duty step.
- DW, default $clog2(PWM_INTERVAL+1): duty width (11 at default).
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  high = advance on strobes; low = hold all state.
- restart  in  1  synchronous return to start of phase 0, without a full reset.
- period_done  in  1  one-cycle strobe from the downstream PWM stage at each period boundary.
- duty_r, duty_g, duty_b  out  DW  registered active-high duty (0 = off, PWM_INTERVAL = full on).
- duty_update  out  1  one-cycle pulse, concurrent with any change of the duty outputs.
- phase  out  3  current hue phase, 0..5.
- wrap  out  1  one-cycle pulse when phase goes from 5 to 0.

Function
REQ-003 A divider counter div (0..STEP_PERIODS-1) SHALL count accepted strobes. An accepted strobe is period_done=1 with enable=1, rst=0 and restart=0.
REQ-004 An accepted strobe with div=STEP_PERIODS-1 SHALL set div to 0 and perform one step. Any other accepted strobe SHALL only increment div.
REQ-005 A ramp counter k (0..PWM_INTERVAL-1) SHALL increment on each step. On a step at k=PWM_INTERVAL-1, k SHALL go to 0 and phase SHALL advance by one, wrapping 5 to 0.
REQ-006 Duty values SHALL be a function of (phase, k), with F=PWM_INTERVAL:
- phase 0: R=F, G=k, B=0
- phase 1: R=F-k, G=F, B=0
- phase 2: R=0, G=F, B=k
- phase 3: R=0, G=F-k, B=F
- phase 4: R=k, G=0, B=F
- phase 5: R=F, G=0, B=F-k
REQ-007 Duty outputs, phase, duty_update and wrap SHALL be registered. They SHALL reflect a step in the cycle after the strobe that caused it (latency 1 cycle).
REQ-008 duty_update SHALL pulse for exactly one cycle per step and per restart, and SHALL be 0 otherwise.
REQ-009 wrap SHALL pulse for exactly one cycle on the step taking phase 5, k=F-1 to phase 0, k=0.
REQ-010 enable=0 SHALL ignore period_done and hold div, k, phase and the duty outputs; duty_update and wrap SHALL be 0.
REQ-011 restart=1 SHALL set div=0, k=0 and phase=0, load phase-0 duties, and pulse duty_update. restart SHALL take priority over a simultaneous strobe and over enable=0.
REQ-012 The arithmetic F-k SHALL be computed at DW bits and SHALL never underflow, since k<=F-1. Duty values SHALL stay within 0..F.
REQ-013 With STEP_PERIODS=1, every accepted strobe SHALL be a step; div SHALL be constant 0.

Reset
REQ-014 rst=1 at a clock edge SHALL give div=0, k=0, phase=0, duty_r=F, duty_g=0, duty_b=0, duty_update=0 and wrap=0. rst SHALL take priority over restart, enable and period_done, including when asserted mid-phase.

Structure
REQ-015 Package rgb_pkg SHALL hold:
- the phase enum typedef (PH_RG_UP, PH_R_DN, PH_GB_UP, PH_G_DN, PH_BR_UP, PH_B_DN), 3 bits;
- the PWM_INTERVAL and STEP_PERIODS default constants.
REQ-016 The divider SHALL be a sub-module strobe_divider (parameter N) that emits a one-cycle tick every N accepted strobes. Ramp, phase and the duty map SHALL be in rgb_hue_sequencer.

Verification (PWM_INTERVAL=4, STEP_PERIODS=2)
REQ-017 Reset: hold rst 2 cycles -> duty_r=4, duty_g=0, duty_b=0, phase=0, duty_update=0.
REQ-018 Step and latency: 2 strobes -> one cycle after the 2nd strobe, duty_g=1 with duty_update=1 for 1 cycle; the 1st strobe produces no update.
REQ-019 Phase boundary: 8 strobes -> phase=1, duty_r=4, duty_g=4; 2 more strobes -> duty_r=3.
REQ-020 Full wheel: 48 strobes -> wrap pulses once, concurrent with phase=0 and (4,0,0).
REQ-021 Hold and priority: enable=0 with 5 strobes -> no change and no pulses. Then restart and a strobe in the same cycle -> (4,0,0), phase 0, duty_update=1.
REQ-022 Mid-op reset: rst in phase 3 with k=2 -> next cycle (4,0,0), phase 0; the first step after release gives duty_g=1.
